// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: holds PC, computes PC+4 with bit 31 protected,
// selects the next fetch address and buffers a redirect that arrives during a stall.
// Latency: redirects take effect at the next rising edge. A stall holds PC; exception and irq ignore the stall.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        irq,
  input  logic        exception,
  output logic [31:0] PC_out,
  output logic [31:0] PC_add_4_out,
  output logic        IF_ID_flush,
  output logic        irq_taken
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic        pending_valid_q, pending_valid_d;
  logic [31:0] pending_target_q, pending_target_d;

  logic [31:0] branch_aligned;
  logic [31:0] jr_aligned;
  logic [31:0] jump_aligned;

  assign PC_out = pc_q;

  // Carry out of bit 30 is dropped so the kernel/user bit never flips.
  assign PC_add_4_out = {pc_q[31], pc_q[30:0] + 31'd4};

  // Interrupts are masked while running in kernel mode or when an exception wins.
  assign irq_taken = irq & ~pc_q[31] & ~exception;

  // Jumps stay in the current mode: bit 31 comes from the current PC.
  assign branch_aligned = branch_target & ALIGN_MASK;
  assign jr_aligned     = jr_target & ALIGN_MASK;
  assign jump_aligned   = (jump_target & 32'h7FFF_FFFC) | {pc_q[31], 31'b0};

  // Next-PC selection, stall buffering and flush generation.
  always_comb begin
    pc_d             = pc_q;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
    IF_ID_flush      = 1'b0;

    if (exception) begin
      pc_d            = ILLOP_PC & ALIGN_MASK;
      pending_valid_d = 1'b0;
      IF_ID_flush     = 1'b1;
    end else if (irq_taken) begin
      pc_d            = XADR_PC & ALIGN_MASK;
      pending_valid_d = 1'b0;
      IF_ID_flush     = 1'b1;
    end else if (PC_write) begin
      // A fresh branch from EX is younger than any buffered redirect and wins.
      pending_valid_d = 1'b0;
      if (branch_taken) begin
        pc_d        = branch_aligned;
        IF_ID_flush = 1'b1;
      end else if (pending_valid_q) begin
        pc_d        = pending_target_q;
        IF_ID_flush = 1'b1;
      end else if (jr) begin
        pc_d        = jr_aligned;
        IF_ID_flush = 1'b1;
      end else if (jump) begin
        pc_d        = jump_aligned;
        IF_ID_flush = 1'b1;
      end else begin
        pc_d = PC_add_4_out;
      end
    end else begin
      // Stalled: PC holds. The first redirect is captured; once one is held,
      // only a branch (resolved later in EX) may replace it.
      if (!pending_valid_q) begin
        if (branch_taken) begin
          pending_target_d = branch_aligned;
          pending_valid_d  = 1'b1;
        end else if (jr) begin
          pending_target_d = jr_aligned;
          pending_valid_d  = 1'b1;
        end else if (jump) begin
          pending_target_d = jump_aligned;
          pending_valid_d  = 1'b1;
        end
      end else if (branch_taken) begin
        pending_target_d = branch_aligned;
      end
    end
  end

  // State registers; reset discards any buffered redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      pending_valid_q  <= 1'b0;
      pending_target_q <= 32'h0;
    end else begin
      pc_q             <= pc_d;
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus randomized traffic
// checked against a behavioural next-PC model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PC_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        irq = 1'b0;
  logic        exception = 1'b0;
  logic [31:0] PC_out;
  logic [31:0] PC_add_4_out;
  logic        IF_ID_flush;
  logic        irq_taken;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_pc = RESET_PC;
  logic        m_pv = 1'b0;
  logic [31:0] m_pt = '0;

  pc_fetch_unit #(
    .RESET_PC(RESET_PC),
    .ILLOP_PC(ILLOP_PC),
    .XADR_PC (XADR_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PC_write     (PC_write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jr           (jr),
    .jr_target    (jr_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .irq          (irq),
    .exception    (exception),
    .PC_out       (PC_out),
    .PC_add_4_out (PC_add_4_out),
    .IF_ID_flush  (IF_ID_flush),
    .irq_taken    (irq_taken)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // PC+4 keeping the mode bit: add in the low 31 bits, reattach bit 31.
  function automatic logic [31:0] seq4(input logic [31:0] a);
    return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  task automatic set_idle();
    PC_write = 1'b1; branch_taken = 1'b0; jr = 1'b0; jump = 1'b0;
    irq = 1'b0; exception = 1'b0;
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic        irq_ok, fl;
    logic [31:0] jt, bt, rt;
    @(negedge clk);
    irq_ok = irq && !m_pc[31] && !exception;
    fl = exception || irq_ok || (PC_write && (branch_taken || m_pv || jr || jump));
    check_val("pc", PC_out, m_pc);
    check_val("pc4", PC_add_4_out, seq4(m_pc));
    check_val("flush", {31'b0, IF_ID_flush}, {31'b0, fl});
    check_val("irq_taken", {31'b0, irq_taken}, {31'b0, irq_ok});
    @(posedge clk);
    bt = {branch_target[31:2], 2'b00};
    rt = {jr_target[31:2], 2'b00};
    jt = {m_pc[31], jump_target[30:2], 2'b00};
    if (exception) begin
      m_pc = ILLOP_PC; m_pv = 1'b0;
    end else if (irq_ok) begin
      m_pc = XADR_PC; m_pv = 1'b0;
    end else if (PC_write) begin
      if (branch_taken)  m_pc = bt;
      else if (m_pv)     m_pc = m_pt;
      else if (jr)       m_pc = rt;
      else if (jump)     m_pc = jt;
      else               m_pc = seq4(m_pc);
      m_pv = 1'b0;
    end else if (m_pv) begin
      if (branch_taken) m_pt = bt;
    end else if (branch_taken || jr || jump) begin
      m_pv = 1'b1;
      m_pt = branch_taken ? bt : (jr ? rt : jt);
    end
    #1;
  endtask

  task automatic goto(input logic [31:0] addr);
    set_idle();
    jr = 1'b1; jr_target = addr;
    tick();
    set_idle();
  endtask

  initial begin
    // Reset state
    set_idle();
    @(posedge clk); #1;
    check_val("rst_pc", PC_out, 32'h8000_0000);
    check_val("rst_pc4", PC_add_4_out, 32'h8000_0004);
    check_val("rst_flush", {31'b0, IF_ID_flush}, 32'd0);
    check_val("rst_irq", {31'b0, irq_taken}, 32'd0);
    reset = 1'b0;

    // Sequential run
    tick(); check_val("seq1", PC_out, 32'h8000_0004);
    tick(); check_val("seq2", PC_out, 32'h8000_0008);
    tick(); check_val("seq3", PC_out, 32'h8000_000C);

    // Jump keeps user mode
    goto(32'h0000_0100);
    check_val("jr_pc", PC_out, 32'h0000_0100);
    jump = 1'b1; jump_target = 32'h8000_0400;
    tick(); set_idle();
    check_val("jump_pc", PC_out, 32'h0000_0400);

    // Stall: jump captured, branch overwrites, release applies branch target
    PC_write = 1'b0; jump = 1'b1; jump_target = 32'h0000_0200;
    tick();
    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0300;
    tick();
    branch_taken = 1'b0;
    tick();
    check_val("stall_hold", PC_out, 32'h0000_0400);
    PC_write = 1'b1;
    tick();
    check_val("release_pc", PC_out, 32'h0000_0300);
    tick();

    // irq masked in kernel mode, accepted in user mode
    goto(32'h8000_0040);
    irq = 1'b1;
    tick();
    check_val("irq_masked", PC_out, 32'h8000_0044);
    goto(32'h0000_0040);
    irq = 1'b1;
    tick(); set_idle();
    check_val("irq_vec", PC_out, 32'h8000_0008);

    // Exception during stall clears a pending redirect
    goto(32'h0000_0080);
    PC_write = 1'b0; jr = 1'b1; jr_target = 32'h0000_0500;
    tick();
    jr = 1'b0; exception = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0600;
    tick(); set_idle();
    check_val("exc_pc", PC_out, 32'h8000_0004);
    tick();
    check_val("exc_no_pend", PC_out, 32'h8000_0008);

    // Sequential wrap in both modes
    goto(32'h7FFF_FFFC);
    tick();
    check_val("wrap_user", PC_out, 32'h0000_0000);
    goto(32'hFFFF_FFFC);
    tick();
    check_val("wrap_kern", PC_out, 32'h8000_0000);

    // Reset mid-stall discards pending redirect
    goto(32'h0000_0600);
    PC_write = 1'b0; jump = 1'b1; jump_target = 32'h0000_0700;
    tick();
    jump = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_val("mid_rst_pc", PC_out, 32'h8000_0000);
    m_pc = RESET_PC; m_pv = 1'b0;
    #1 reset = 1'b0;
    PC_write = 1'b1;
    tick();
    check_val("mid_rst_rel", PC_out, 32'h8000_0004);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      PC_write      = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      jr            = ($urandom_range(0, 11) == 0);
      jump          = ($urandom_range(0, 11) == 0);
      irq           = ($urandom_range(0, 9) == 0);
      exception     = ($urandom_range(0, 24) == 0);
      branch_target = $urandom;
      jr_target     = $urandom;
      jump_target   = $urandom;
      tick();
    end
    set_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
